// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive-FIFO drain controller.
package i2s_pkg;

  localparam int unsigned I2S_FIFO_DEPTH = 32;
  localparam int unsigned I2S_LVL_W      = 6;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StXfer,
    StDone
  } state_e;

  // The FIFO level port wraps to 0 when full; rebuild the true occupancy.
  function automatic logic [I2S_LVL_W-1:0] eff_level(input logic       full,
                                                     input logic [4:0] level);
    return full ? I2S_LVL_W'(I2S_FIFO_DEPTH) : {1'b0, level};
  endfunction

endpackage

// File: rtl/i2s_drain_timer.sv
// Saturating idle timer: counts while enabled, holds at limit, clears on demand.
module i2s_drain_timer #(
  parameter int unsigned TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [TW-1:0] limit,
  output logic          expired
);

  logic [TW-1:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d = tmr_q;
    if (clr) begin
      tmr_d = '0;
    end else if (en) begin
      // Saturate even if limit is lowered below the current count.
      tmr_d = (tmr_q >= limit) ? limit : tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign expired = (tmr_q == limit);

endmodule

// File: rtl/i2s_drain_ctrl.sv
// Burst-drain controller: pops the I2S receive FIFO in bursts onto a registered
// valid/ready stream, with idle-timeout flush and sticky overflow detection.
module i2s_drain_ctrl
  import i2s_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [4:0]    burst_len,
  input  logic [TW-1:0] timeout,
  input  logic [4:0]    fifo_level,
  input  logic          fifo_full,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_rdata,
  output logic          fifo_rd,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          irq_done,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [15:0]   word_cnt
);

  state_e                 state_q, state_d;
  logic [I2S_LVL_W-1:0]   remaining_q, remaining_d;
  logic                   m_valid_q, m_valid_d;
  logic                   m_last_q, m_last_d;
  logic [DW-1:0]          m_data_q, m_data_d;
  logic                   ovf_q, ovf_d;
  logic [15:0]            word_cnt_q, word_cnt_d;

  logic [I2S_LVL_W-1:0]   lvl;
  logic [I2S_LVL_W-1:0]   blen;
  logic                   out_free;
  logic                   out_hs;
  logic                   tmr_clr;
  logic                   tmr_en;
  logic                   tmr_expired;

  assign lvl      = eff_level(fifo_full, fifo_level);
  assign blen     = (burst_len == '0) ? I2S_LVL_W'(1) : {1'b0, burst_len};
  assign out_free = !m_valid_q || m_ready;
  assign out_hs   = m_valid_q && m_ready;
  assign tmr_clr  = (state_q != StWait) || (lvl == '0);
  assign tmr_en   = (state_q == StWait);

  i2s_drain_timer #(
    .TW(TW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .limit  (timeout),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    fifo_rd     = 1'b0;
    case (state_q)
      StIdle: begin
        if (en) state_d = StWait;
      end
      StWait: begin
        if (!en) begin
          state_d = StIdle;
        end else if (lvl >= blen) begin
          remaining_d = blen;
          state_d     = StXfer;
        end else if ((timeout != '0) && (lvl != '0) && tmr_expired) begin
          remaining_d = lvl;
          state_d     = StXfer;
        end
      end
      StXfer: begin
        // en is ignored here so a started burst always completes in full.
        fifo_rd = (remaining_q != '0) && !fifo_empty && out_free;
        if (fifo_rd) remaining_d = remaining_q - 1'b1;
        if ((remaining_q == '0) && out_free) state_d = StDone;
      end
      StDone: begin
        state_d = en ? StWait : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_data_d   = m_data_q;
    word_cnt_d = word_cnt_q;
    if (fifo_rd) begin
      m_data_d  = fifo_rdata;
      m_valid_d = 1'b1;
      m_last_d  = (remaining_q == I2S_LVL_W'(1));
    end else if (out_hs) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
    if (out_hs) word_cnt_d = word_cnt_q + 16'd1;
    // A set in the same cycle as a clear wins.
    if (fifo_full && en) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      ovf_q       <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_data_q    <= m_data_d;
      ovf_q       <= ovf_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign m_data   = m_data_q;
  assign ovf      = ovf_q;
  assign word_cnt = word_cnt_q;
  assign busy     = (state_q == StXfer) || (state_q == StDone);
  assign irq_done = (state_q == StDone);

endmodule

// File: tb/tb_i2s_drain_ctrl.sv
// Bench for i2s_drain_ctrl: a queue-based FIFO, a behavioural reference model,
// directed scenarios with literal expectations, then a randomized soak.
module tb_i2s_drain_ctrl;

  localparam int PH_IDLE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_XFER = 2;
  localparam int PH_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [4:0]  burst_len = '0;
  logic [15:0] timeout = '0;
  logic [4:0]  fifo_level;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_rdata;
  logic        fifo_rd;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        irq_done;
  logic        ovf;
  logic        ovf_clr = 1'b0;
  logic [15:0] word_cnt;

  i2s_drain_ctrl #(
    .DW(32),
    .TW(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .burst_len (burst_len),
    .timeout   (timeout),
    .fifo_level(fifo_level),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_rd   (fifo_rd),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .irq_done  (irq_done),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] fifo_q[$];
  logic [31:0] sent_q[$];
  logic [31:0] junk;
  bit          rd_seen;

  // Next-cycle stimulus, applied just after the following rising edge.
  bit          nx_en, nx_rdy, nx_push, nx_clr;
  logic [4:0]  nx_bl;
  logic [15:0] nx_to;

  // Reference model state.
  int          e_ph, e_left, e_age, e_cnt;
  bit          e_valid, e_last, e_ovf;
  logic [31:0] e_data;

  int n_chk, n_fail, cyc;
  int n_rd, n_irq, n_hs, n_last, n_bp, n_rd_bp, first_rd, last_rd, first_lvl;
  logic [31:0] last_data, ref_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr_ev();
    n_rd = 0; n_irq = 0; n_hs = 0; n_last = 0; n_bp = 0; n_rd_bp = 0;
    first_rd = -1; last_rd = -1; first_lvl = -1;
  endtask

  task automatic model_reset();
    e_ph = PH_IDLE; e_left = 0; e_age = 0; e_cnt = 0;
    e_valid = 0; e_last = 0; e_ovf = 0; e_data = '0;
  endtask

  task automatic drive_fifo();
    fifo_full  = (fifo_q.size() == 32);
    fifo_level = 5'(fifo_q.size());
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 32'hdead_beef;
  endtask

  task automatic apply();
    logic [31:0] w;
    if (rd_seen) junk = fifo_q.pop_front();
    if (nx_push && fifo_q.size() < 32) begin
      w = $urandom;
      fifo_q.push_back(w);
      sent_q.push_back(w);
    end
    en = nx_en; m_ready = nx_rdy; ovf_clr = nx_clr; burst_len = nx_bl; timeout = nx_to;
    drive_fifo();
  endtask

  task automatic sample();
    int lvl, blen, nph, to;
    bit exp_rd, hs;
    lvl = fifo_q.size();
    to  = int'(timeout);
    exp_rd = (e_ph == PH_XFER) && (e_left != 0) && (lvl != 0) && (!e_valid || m_ready);
    chk("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
    chk("m_valid", 32'(m_valid), 32'(e_valid));
    chk("m_last", 32'(m_last), 32'(e_last));
    chk("m_data", m_data, e_data);
    chk("busy", 32'(busy), 32'(e_ph == PH_XFER || e_ph == PH_DONE));
    chk("irq_done", 32'(irq_done), 32'(e_ph == PH_DONE));
    chk("ovf", 32'(ovf), 32'(e_ovf));
    chk("word_cnt", 32'(word_cnt), 32'(e_cnt));
    if (m_valid && m_ready) begin
      n_hs++;
      if (m_last) n_last++;
      last_data = m_data;
      if (sent_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL order: got %0h expected no word (cycle %0d)", m_data, cyc);
      end else begin
        ref_word = sent_q.pop_front();
        chk("order", m_data, ref_word);
      end
    end
    if (m_valid && !m_ready) begin
      n_bp++;
      if (fifo_rd) n_rd_bp++;
    end
    if (fifo_rd) begin
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    if (irq_done) n_irq++;
    if (lvl != 0 && first_lvl < 0) first_lvl = cyc;
    rd_seen = fifo_rd;

    // Advance the reference model by one clock using this cycle's inputs.
    blen = (burst_len == 0) ? 1 : int'(burst_len);
    hs   = e_valid && m_ready;
    nph  = e_ph;
    case (e_ph)
      PH_IDLE: if (en) nph = PH_WAIT;
      PH_WAIT: begin
        if (!en) nph = PH_IDLE;
        else if (lvl >= blen) begin e_left = blen; nph = PH_XFER; end
        else if (to != 0 && lvl != 0 && e_age == to) begin e_left = lvl; nph = PH_XFER; end
      end
      PH_XFER: if (e_left == 0 && (!e_valid || m_ready)) nph = PH_DONE;
      default: nph = en ? PH_WAIT : PH_IDLE;
    endcase
    e_age = (e_ph == PH_WAIT && lvl != 0) ? ((e_age + 1 > to) ? to : e_age + 1) : 0;
    if (exp_rd) begin
      e_data = fifo_q[0]; e_valid = 1; e_last = (e_left == 1); e_left--;
    end else if (hs) begin
      e_valid = 0; e_last = 0;
    end
    if (hs) e_cnt = (e_cnt + 1) % 65536;
    if (lvl == 32 && en) e_ovf = 1;
    else if (ovf_clr) e_ovf = 0;
    e_ph = nph;
    cyc++;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    apply();
    @(negedge clk);
    sample();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq_done", 32'(irq_done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    model_reset();
    rd_seen = 0;
    sent_q = fifo_q;  // the in-flight word is dropped; queued words remain
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply();
    @(negedge clk);
    sample();
  endtask

  logic [31:0] a3;

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    clr_ev();
    model_reset();
    nx_en = 0; nx_rdy = 0; nx_push = 0; nx_clr = 0; nx_bl = '0; nx_to = '0;
    rd_seen = 0;
    apply();
    #1;
    do_reset();

    // Threshold burst of 4 with the sink always ready.
    nx_rdy = 1; nx_bl = 5'd4; nx_push = 1;
    run(4);
    nx_push = 0;
    a3 = fifo_q[3];
    clr_ev();
    nx_en = 1;
    run(12);
    chk("thr_pops", 32'(n_rd), 32'd4);
    chk("thr_pops_consecutive", 32'(last_rd - first_rd), 32'd3);
    chk("thr_last_count", 32'(n_last), 32'd1);
    chk("thr_last_word", last_data, a3);
    chk("thr_irq", 32'(n_irq), 32'd1);
    chk("thr_word_cnt", 32'(word_cnt), 32'd4);

    // Backpressure with ready pattern 1,0,0,1.
    clr_ev();
    for (int i = 0; i < 28; i++) begin
      nx_push = (i < 4);
      nx_rdy = (i % 4 == 0) || (i % 4 == 3);
      cycle();
    end
    chk("bp_pops", 32'(n_rd), 32'd4);
    chk("bp_delivered", 32'(n_hs), 32'd4);
    chk("bp_stalls_seen", 32'(n_bp > 0), 32'd1);
    chk("bp_pop_while_stalled", 32'(n_rd_bp), 32'd0);
    chk("bp_irq", 32'(n_irq), 32'd1);
    chk("bp_word_cnt", 32'(word_cnt), 32'd8);

    // Timeout flush of a 3-word partial burst.
    nx_rdy = 1; nx_bl = 5'd8; nx_to = 16'd10; nx_push = 0;
    run(2);
    clr_ev();
    nx_push = 1;
    run(3);
    nx_push = 0;
    a3 = fifo_q[2];
    run(25);
    // Flush is sampled 10 cycles after the level rises; the first pop is the next cycle.
    chk("to_first_pop_delay", 32'(first_rd - first_lvl), 32'd11);
    chk("to_pops", 32'(n_rd), 32'd3);
    chk("to_last_word", last_data, a3);
    chk("to_last_count", 32'(n_last), 32'd1);
    chk("to_irq", 32'(n_irq), 32'd1);

    // Completely full FIFO (level port wraps to 0), burst of 31.
    nx_en = 0; nx_to = 16'd0; nx_bl = 5'd31; nx_push = 1;
    run(32);
    nx_push = 0;
    clr_ev();
    nx_en = 1;
    run(40);
    chk("full_pops", 32'(n_rd), 32'd31);
    chk("full_left_in_fifo", 32'(fifo_q.size()), 32'd1);
    chk("full_ovf_set", 32'(ovf), 32'd1);
    chk("full_last_count", 32'(n_last), 32'd1);
    nx_clr = 1;
    run(1);
    nx_clr = 0;
    run(1);
    chk("full_ovf_cleared", 32'(ovf), 32'd0);

    // burst_len = 0 behaves as 1 on the remaining word.
    clr_ev();
    nx_bl = 5'd0;
    run(8);
    chk("bl0_pops", 32'(n_rd), 32'd1);
    chk("bl0_last", 32'(n_last), 32'd1);
    chk("bl0_irq", 32'(n_irq), 32'd1);
    chk("bl0_fifo_empty", 32'(fifo_q.size()), 32'd0);

    // Dropping en mid-burst still completes all 4 words, then stays idle.
    nx_en = 0; nx_bl = 5'd4;
    run(2);
    nx_push = 1;
    run(4);
    nx_push = 0;
    clr_ev();
    nx_en = 1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (n_rd >= 2) nx_en = 0;
    end
    chk("endrop_delivered", 32'(n_hs), 32'd4);
    chk("endrop_last", 32'(n_last), 32'd1);
    chk("endrop_irq", 32'(n_irq), 32'd1);
    nx_push = 1;
    run(4);
    nx_push = 0;
    clr_ev();
    run(6);
    chk("endrop_idle_no_pop", 32'(n_rd), 32'd0);
    chk("endrop_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a burst.
    clr_ev();
    nx_en = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (n_hs >= 2) break;
    end
    chk("rst_mid_progress", 32'(n_hs), 32'd2);
    do_reset();
    nx_bl = 5'd1;
    run(12);

    // Randomized soak.
    for (int i = 0; i < 3000; i++) begin
      nx_en   = ($urandom_range(0, 15) != 0);
      nx_rdy  = ($urandom_range(0, 3) != 0);
      nx_push = ($urandom_range(0, 2) != 0);
      nx_clr  = ($urandom_range(0, 31) == 0);
      if (i % 64 == 0) begin
        nx_bl = 5'($urandom_range(0, 12));
        case ($urandom_range(0, 3))
          0: nx_to = 16'd0;
          1: nx_to = 16'd3;
          2: nx_to = 16'd6;
          default: nx_to = 16'd15;
        endcase
      end
      cycle();
      if (i == 1500) do_reset();
    end

    // Drain everything that is left and confirm every word came out in order.
    nx_en = 1; nx_rdy = 1; nx_push = 0; nx_clr = 0; nx_bl = 5'd1; nx_to = 16'd0;
    run(120);
    chk("soak_fifo_drained", 32'(fifo_q.size()), 32'd0);
    chk("soak_all_delivered", 32'(sent_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
